// File: rtl/apb_resp_regfile.sv
// APB3 completer with a small register file, wait states, slave-error decode and saturating counters.
// Optional macro APB_RESP_RAND_WAIT_EN: wait states come from a 16-bit Galois LFSR instead of WAIT_CYCLES.
module apb_resp_regfile #(
  parameter int unsigned           ADDR_WIDTH  = 20,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           RO_START    = 12,
  parameter int unsigned           WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] apb_paddr,
  input  logic                  apb_psel,
  input  logic                  apb_penable,
  input  logic                  apb_pwrite,
  input  logic [DATA_WIDTH-1:0] apb_pwdata,
  output logic [DATA_WIDTH-1:0] apb_prdata,
  output logic                  apb_pready,
  output logic                  apb_pslverr,
  output logic [15:0]           wr_cnt,
  output logic [15:0]           rd_cnt,
  output logic [7:0]            err_cnt,
  output logic                  proto_err
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] RO_START_IDX = IDX_W'(RO_START);

  state_e                state_q;
  logic [3:0]            wait_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [15:0]           wr_cnt_q, wr_cnt_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  proto_err_q;

  logic [IDX_W-1:0]      idx;
  logic [SEL_W-1:0]      reg_sel;
  logic                  dec_err;
  logic                  ready;
  logic                  complete;
  logic [3:0]            wait_load;

  // Decode always works on the latched request so bus changes during ACCESS are ignored.
  assign idx      = addr_q[ADDR_WIDTH-1:2];
  assign reg_sel  = idx[SEL_W-1:0];
  assign dec_err  = (addr_q[1:0] != 2'b00) || (idx >= NUM_REGS_IDX) ||
                    (write_q && (idx >= RO_START_IDX));
  assign ready    = (state_q == ACCESS) && (wait_q == 4'd0);
  assign complete = ready && apb_psel && apb_penable;

  assign apb_pready  = ready;
  assign apb_pslverr = ready && dec_err;
  assign apb_prdata  = (ready && !dec_err && !write_q) ? regs_q[reg_sel] : '0;

`ifdef APB_RESP_RAND_WAIT_EN
  logic [15:0] lfsr_q;

  // Right-shifting Galois form; 16'hB400 encodes taps 16,14,13,11.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (complete) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign wait_load = lfsr_q[3:0];
`else
  assign wait_load = 4'(WAIT_CYCLES);
`endif

  // NOTE: sequential state uses <= so every register samples pre-edge values; = here would race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (apb_penable) begin
            proto_err_q <= 1'b1;
          end else if (apb_psel) begin
            state_q <= ACCESS;
            wait_q  <= wait_load;
            addr_q  <= apb_paddr;
            write_q <= apb_pwrite;
            wdata_q <= apb_pwdata;
          end
        end
        ACCESS: begin
          if (!(apb_psel && apb_penable)) begin
            proto_err_q <= 1'b1;
            state_q     <= IDLE;
          end else if (wait_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the register file has a defined reset value, so it is reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (complete && write_q && !dec_err) begin
      regs_q[reg_sel] <= wdata_q;
    end
  end

  // NOTE: each _d gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (complete) begin
      if (dec_err) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (write_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= 16'd0;
      rd_cnt_q  <= 16'd0;
      err_cnt_q <= 8'd0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_resp_regfile.sv
// Self-checking bench for apb_resp_regfile: directed and random APB transfers against a register-file model.
module tb_apb_resp_regfile;

  localparam int          AW    = 20;
  localparam int          DW    = 32;
  localparam int          NREGS = 16;
  localparam int          RO    = 12;
  localparam int          WAITC = 2;
  localparam logic [31:0] RV    = 32'hA5A5_0000;

  logic          clk;
  logic          rst;
  logic [AW-1:0] apb_paddr;
  logic          apb_psel;
  logic          apb_penable;
  logic          apb_pwrite;
  logic [DW-1:0] apb_pwdata;
  logic [DW-1:0] apb_prdata;
  logic          apb_pready;
  logic          apb_pslverr;
  logic [15:0]   wr_cnt;
  logic [15:0]   rd_cnt;
  logic [7:0]    err_cnt;
  logic          proto_err;

  apb_resp_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NREGS),
    .RO_START   (RO),
    .WAIT_CYCLES(WAITC),
    .RESET_VAL  (RV)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .apb_paddr  (apb_paddr),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_pwdata (apb_pwdata),
    .apb_prdata (apb_prdata),
    .apb_pready (apb_pready),
    .apb_pslverr(apb_pslverr),
    .wr_cnt     (wr_cnt),
    .rd_cnt     (rd_cnt),
    .err_cnt    (err_cnt),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  logic [31:0] m_regs [NREGS];
  int          m_wr;
  int          m_rd;
  int          m_err;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int exp_wait();
`ifdef APB_RESP_RAND_WAIT_EN
    return int'(m_lfsr % 16);
`else
    return WAITC;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = RV;
    m_wr   = 0;
    m_rd   = 0;
    m_err  = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(sat(m_wr, 65535)));
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(sat(m_rd, 65535)));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(sat(m_err, 255)));
  endtask

  // Entered and left just after a rising edge; leaves the bus idle so a following call is back-to-back.
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd);
    int  waits;
    int  exp_w;
    bit  done;
    bit  merr;
    int  idx;
    exp_w = exp_wait();
    idx   = int'(addr / 4);
    merr  = (addr % 4 != 0) || (idx >= NREGS) || (wr && idx >= RO);
    apb_paddr   = addr;
    apb_pwrite  = wr;
    apb_pwdata  = wd;
    apb_psel    = 1'b1;
    apb_penable = 1'b0;
    @(posedge clk);
    #1;
    apb_penable = 1'b1;
    apb_paddr   = ~addr;
    apb_pwrite  = ~wr;
    apb_pwdata  = ~wd;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (apb_pready) begin
        done = 1'b1;
      end else begin
        check("wait_prdata_zero", apb_prdata, 32'h0);
        check("wait_pslverr_zero", 32'(apb_pslverr), 32'h0);
        waits++;
        @(posedge clk);
        #1;
      end
    end
    check("pready_seen", 32'(done), 32'h1);
    check("wait_states", 32'(waits), 32'(exp_w));
    check("pslverr", 32'(apb_pslverr), 32'(merr));
    if (!wr) check("prdata", apb_prdata, merr ? 32'h0 : m_regs[idx]);
    @(posedge clk);
    #1;
    if (merr) m_err++;
    else if (wr) begin
      m_regs[idx] = wd;
      m_wr++;
    end else m_rd++;
    m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 16'hB400 : 16'h0000);
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    int            sel;
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    apb_paddr   = '0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
    apb_pwdata  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", 32'(apb_pready), 32'h0);
    check("rst_pslverr", 32'(apb_pslverr), 32'h0);
    check("rst_prdata", apb_prdata, 32'h0);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    check_counters("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset-value read, then write/read round trip
    apb_xfer(20'h00000, 1'b0, 32'h0);
    apb_xfer(20'h00004, 1'b1, 32'h1234_5678);
    apb_xfer(20'h00004, 1'b0, 32'h0);
    check_counters("basic");

    // Out-of-range and misaligned reads
    apb_xfer(20'h00040, 1'b0, 32'h0);
    apb_xfer(20'h00002, 1'b0, 32'h0);
    check_counters("decode_err");

    // Read-only region rejects writes but is readable
    apb_xfer(20'h00030, 1'b1, 32'hFFFF_FFFF);
    apb_xfer(20'h00030, 1'b0, 32'h0);
    apb_xfer(20'h0003C, 1'b0, 32'h0);
    check_counters("ro");

    // Randomized back-to-back traffic with occasional idle cycles
    for (int t = 0; t < 100; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      a = AW'($urandom_range(0, NREGS - 1) * 4);
      else if (sel == 7) a = AW'($urandom_range(0, NREGS - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = AW'($urandom_range(NREGS, 255) * 4);
      else               a = AW'($urandom_range(1, 15) << 16);
      apb_xfer(a, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    check_counters("random");

    // Drop psel mid-ACCESS: one proto_err pulse and no commit
    apb_paddr   = 20'h00008;
    apb_pwrite  = 1'b1;
    apb_pwdata  = 32'hBAD0_BAD0;
    apb_psel    = 1'b1;
    apb_penable = 1'b0;
    @(posedge clk);
    #1;
    apb_penable = 1'b1;
    if (exp_wait() > 0) begin
      @(posedge clk);
      #1;
    end
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    @(negedge clk);
    check("abort_pready", 32'(apb_pready), 32'h0);
    @(negedge clk);
    check("abort_proto_pulse", 32'(proto_err), 32'h1);
    @(negedge clk);
    check("abort_proto_clear", 32'(proto_err), 32'h0);
    check_counters("abort");
    @(posedge clk);
    #1;
    apb_xfer(20'h00008, 1'b0, 32'h0);

    // penable without a setup phase in IDLE
    apb_penable = 1'b1;
    @(posedge clk);
    #1;
    apb_penable = 1'b0;
    @(negedge clk);
    check("idle_penable_proto", 32'(proto_err), 32'h1);
    @(negedge clk);
    check("idle_penable_clear", 32'(proto_err), 32'h0);
    check_counters("idle_penable");
    @(posedge clk);
    #1;

    // Reset during a write aborts it and clears everything
    apb_paddr   = 20'h00014;
    apb_pwrite  = 1'b1;
    apb_pwdata  = 32'h5555_5555;
    apb_psel    = 1'b1;
    apb_penable = 1'b0;
    @(posedge clk);
    #1;
    apb_penable = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_pready", 32'(apb_pready), 32'h0);
    check_counters("midrst");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
    @(posedge clk);
    #1;
    apb_xfer(20'h00014, 1'b0, 32'h0);
    apb_xfer(20'h00004, 1'b0, 32'h0);
    apb_xfer(20'h00018, 1'b1, 32'hCAFE_F00D);
    apb_xfer(20'h00018, 1'b0, 32'h0);
    check_counters("post_rst");

    // err_cnt saturation
    for (int t = 0; t < 260; t++) apb_xfer(20'h0007C, 1'b0, 32'h0);
    check_counters("err_sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_resp_regfile.md
Name: apb_resp_regfile

Overview:
- APB3 completer (responder) for the `apb_xactor` initiator used on engine benches.
- Provides a small register file with configurable wait states, error responses, a read-only region and transfer counters.
- Sits on the `apb_*` bus in place of, or beside, an engine register block.
- Used to bring up bus-level sequencing, including slave-error and timeout paths, before real CSR blocks are available.

Parameters:
- ADDR_WIDTH, 20: width of apb_paddr (matches N_RBUS_ADDR_BITS).
- DATA_WIDTH, 32: width of apb_pwdata/apb_prdata (matches N_RBUS_DATA_BITS).
- NUM_REGS, 16: number of 32-bit registers; byte addresses 0 .. NUM_REGS*4-1 are valid.
- RO_START, 12: register index at or above which registers are read-only.
- WAIT_CYCLES, 0: fixed wait states inserted before pready (0..15).
- RESET_VAL, 32'h0: reset value of every register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- apb_paddr  in  ADDR_WIDTH  byte address.
- apb_psel  in  1  select.
- apb_penable  in  1  access phase.
- apb_pwrite  in  1  1=write, 0=read.
- apb_pwdata  in  DATA_WIDTH  write data.
- apb_prdata  out  DATA_WIDTH  read data; valid only while apb_pready=1.
- apb_pready  out  1  transfer complete.
- apb_pslverr  out  1  error response; valid only while apb_pready=1.
- wr_cnt  out  16  count of successful writes; saturates at 16'hFFFF.
- rd_cnt  out  16  count of successful reads; saturates.
- err_cnt  out  8  count of pslverr responses; saturates.
- proto_err  out  1  one-cycle pulse on an APB protocol violation.

Behaviour:
- Reset (async on rst rising):
  - registers = RESET_VAL; FSM = IDLE; wait counter = 0.
  - all counters = 0; apb_pready, apb_pslverr, proto_err = 0; apb_prdata = 0.
  - Reset mid-transfer aborts the transfer with no commit.
- FSM states: IDLE, ACCESS.
- IDLE:
  - apb_psel=1 and apb_penable=0 (setup) → ACCESS; wait counter loads WAIT_CYCLES; address, write flag and wdata are latched.
  - apb_penable=1 in IDLE → proto_err pulse next cycle; stay in IDLE.
- ACCESS:
  - apb_pready = 1 combinationally iff wait counter == 0; otherwise the counter decrements each cycle.
  - Completion edge: apb_psel & apb_penable & apb_pready sampled → return to IDLE.
  - apb_psel=0 or apb_penable=0 while in ACCESS → proto_err pulse; return to IDLE; no commit, no count.
  - Latched address or control changing during ACCESS is ignored; the latched values are used.
- Zero-wait transfer takes 2 cycles (setup + access). Each wait state adds one cycle. Back-to-back transfers with no idle cycle are supported: setup directly follows completion.
- Decode, from the latched address:
  - idx = paddr[ADDR_WIDTH-1:2].
  - Error if paddr[1:0] != 0, or idx >= NUM_REGS, or (write and idx >= RO_START).
- Completion behaviour:
  - Error: apb_pslverr=1 with apb_pready; no register update; apb_prdata=0; err_cnt+1.
  - OK write: reg[idx] ← latched pwdata at the completion edge; wr_cnt+1.
  - OK read: apb_prdata = reg[idx] while apb_pready; rd_cnt+1.
  - apb_prdata=0 and apb_pslverr=0 whenever apb_pready=0.
- Counters saturate; they never wrap.

Optional Feature:
- Macro: APB_RESP_RAND_WAIT_EN.
- Defined:
  - The wait counter loads from a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) instead of WAIT_CYCLES.
  - Load value = lfsr[3:0].
  - The LFSR advances one step per completed transfer.
- Not defined: fixed WAIT_CYCLES; no LFSR logic is instantiated.

Test Plan:
- Write 0x12345678 to 0x004, then read 0x004, with WAIT_CYCLES=0 → each transfer completes in 2 cycles; read prdata=0x12345678, pslverr=0; wr_cnt=1, rd_cnt=1.
- WAIT_CYCLES=3; read 0x000 after reset → pready low for 3 access cycles, high on the 4th; prdata=RESET_VAL; 5 cycles total.
- Read 0x040 (idx 16), then read 0x002 (misaligned) → pready=1 with pslverr=1 and prdata=0 for both; err_cnt=2; registers unchanged.
- Write 0xFFFFFFFF to 0x030 (idx 12, read-only), then read 0x030 → write returns pslverr=1; read returns RESET_VAL with pslverr=0.
- Drop psel in the middle of ACCESS with WAIT_CYCLES=2, then assert rst for 1 cycle during a later write → proto_err pulses once; neither write commits; all counters=0 after reset; next transfer completes normally.
- With APB_RESP_RAND_WAIT_EN, run 100 back-to-back writes → every transfer completes within 17 cycles; wait counts match the reference LFSR sequence from 16'hACE1; wr_cnt=100.
